// File: rtl/fifo_16x256_rd_checker.sv
// -----------------------------------------------------------------------------
// fifo_16x256_rd_checker
//   Read-side traffic engine and self-checker for the 16-bit asynchronous FIFO.
//   On a start pulse it drains BURST_LEN words from the FIFO read port.
//   Reads are throttled by i_rd_empty. Every returned word is compared against
//   a descending pattern that begins at SEED and decrements by one per word.
//
// Ports
//   clk               read-side clock (shared with FIFO rd_clk)
//   tb_rst            asynchronous, active-high reset
//   i_start           one-cycle burst start; honoured only in IDLE or DONE
//   i_rd_empty        FIFO empty flag
//   i_rd_data         FIFO read data
//   o_rd_en           FIFO read enable (combinational from state/empty)
//   o_busy            burst in progress (READ or DRAIN)
//   o_done            burst finished; held until the next accepted start
//   o_pass            done with zero mismatches
//   o_word_cnt        words compared in the current burst
//   o_err_cnt         mismatch count, saturating at 255
//   o_first_err_idx   word index of the first mismatch, all-ones if none
// -----------------------------------------------------------------------------
module fifo_16x256_rd_checker #(
    parameter int unsigned          DATA_WIDTH  = 16,
    parameter int unsigned          DEPTH_WIDTH = 8,
    parameter int unsigned          BURST_LEN   = 256,
    parameter int unsigned          OUTPUT_REG  = 0,
    parameter logic [DATA_WIDTH-1:0] SEED       = '1
) (
    input  logic                   clk,
    input  logic                   tb_rst,
    input  logic                   i_start,
    input  logic                   i_rd_empty,
    input  logic [DATA_WIDTH-1:0]  i_rd_data,
    output logic                   o_rd_en,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_pass,
    output logic [DEPTH_WIDTH:0]   o_word_cnt,
    output logic [7:0]             o_err_cnt,
    output logic [DEPTH_WIDTH:0]   o_first_err_idx
);

    localparam int unsigned    CW         = DEPTH_WIDTH + 1;
    localparam int unsigned    LAT        = 1 + OUTPUT_REG;
    localparam logic [CW-1:0]  BURST_C    = CW'(BURST_LEN);
    localparam logic [CW-1:0]  BURST_LAST = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_issued;
    logic [LAT-1:0]        r_vpipe;
    logic [DATA_WIDTH-1:0] r_expected;
    logic [CW-1:0]         r_word_cnt;
    logic [CW-1:0]         r_first_err_idx;
    logic [7:0]            r_err_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_rd_en;
    logic                  w_strobe;
    logic                  w_mismatch;
    logic [LAT:0]          w_vpipe_next;

    assign w_rd_en      = (r_state == S_READ) && !i_rd_empty && (r_issued < BURST_C);
    // Valid pipe mirrors FIFO read latency; its oldest stage marks rd_data valid.
    assign w_vpipe_next = {r_vpipe, w_rd_en};
    assign w_strobe     = r_vpipe[LAT-1];
    assign w_mismatch   = w_strobe && (i_rd_data != r_expected);

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state         <= S_IDLE;
            r_issued        <= '0;
            r_vpipe         <= '0;
            r_expected      <= SEED;
            r_word_cnt      <= '0;
            r_first_err_idx <= '1;
            r_err_cnt       <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_vpipe <= w_vpipe_next[LAT-1:0];

            if (w_rd_en) begin
                r_issued <= r_issued + 1'b1;
            end

            if (w_strobe) begin
                r_expected <= r_expected - 1'b1;
                r_word_cnt <= r_word_cnt + 1'b1;
                if (w_mismatch) begin
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                    // err_cnt only clears on start and never wraps, so zero
                    // identifies the first mismatch of the burst.
                    if (r_err_cnt == '0) begin
                        r_first_err_idx <= r_word_cnt;
                    end
                end
            end

            // Strobes never occur in IDLE/DONE, so the start clears below
            // cannot collide with the compare updates above.
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state         <= S_READ;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_issued        <= '0;
                        r_word_cnt      <= '0;
                        r_err_cnt       <= '0;
                        r_first_err_idx <= '1;
                        r_expected      <= SEED;
                    end
                end
                S_READ: begin
                    if (w_rd_en && (r_issued == BURST_LAST)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Empty pipe: every issued read has been compared.
                    if (r_vpipe == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rd_en         = w_rd_en;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_done && (r_err_cnt == '0);
    assign o_word_cnt      = r_word_cnt;
    assign o_err_cnt       = r_err_cnt;
    assign o_first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_fifo_16x256_rd_checker.sv
// -----------------------------------------------------------------------------
// tb_fifo_16x256_rd_checker
//   Drives two checker instances: instance 0 has OUTPUT_REG=0 and instance 1
//   has OUTPUT_REG=1. Each instance reads from its own queue-based FIFO model.
//   Expected results are derived from the written word list. A word is an
//   error when it differs from 0xFFFF - index. The error count saturates at
//   255. Done must follow the last read by the read latency plus one cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_16x256_rd_checker;

    logic        clk;
    logic        tb_rst;
    logic [1:0]  start;
    logic [1:0]  rd_empty;
    logic [15:0] rd_data [2];
    logic [1:0]  rd_en;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  pass;
    logic [8:0]  wc [2];
    logic [7:0]  ec [2];
    logic [8:0]  fe [2];

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned edge_n = 0;
    int unsigned reads [2];
    int unsigned last_rd [2];
    int unsigned done_edge [2];
    int unsigned viol = 0;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] wbuf [256];
    logic        pipe1_v = 1'b0;
    logic [15:0] pipe1_val = '0;

    fifo_16x256_rd_checker #(
        .DATA_WIDTH(16), .DEPTH_WIDTH(8), .BURST_LEN(256), .OUTPUT_REG(0)
    ) u_dut0 (
        .clk(clk), .tb_rst(tb_rst), .i_start(start[0]), .i_rd_empty(rd_empty[0]),
        .i_rd_data(rd_data[0]), .o_rd_en(rd_en[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_pass(pass[0]), .o_word_cnt(wc[0]), .o_err_cnt(ec[0]), .o_first_err_idx(fe[0])
    );

    fifo_16x256_rd_checker #(
        .DATA_WIDTH(16), .DEPTH_WIDTH(8), .BURST_LEN(256), .OUTPUT_REG(1)
    ) u_dut1 (
        .clk(clk), .tb_rst(tb_rst), .i_start(start[1]), .i_rd_empty(rd_empty[1]),
        .i_rd_data(rd_data[1]), .o_rd_en(rd_en[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_pass(pass[1]), .o_word_cnt(wc[1]), .o_err_cnt(ec[1]), .o_first_err_idx(fe[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int unsigned inst, input logic [15:0] v);
        if (inst == 0) q0.push_back(v);
        else           q1.push_back(v);
    endtask

    task automatic fill_clean();
        for (int i = 0; i < 256; i++) wbuf[i] = 16'(32'hFFFF - i);
    endtask

    // One clock cycle, entered and left at a falling edge. A read granted at
    // the rising edge pops the FIFO model. Its data appears 1 edge later for
    // instance 0 and 2 edges later for instance 1.
    task automatic cyc(input logic [1:0] st);
        logic [1:0]  en;
        logic [15:0] p0;
        logic [15:0] p1;
        p0 = '0;
        p1 = '0;
        start       = st;
        rd_empty[0] = (q0.size() == 0);
        rd_empty[1] = (q1.size() == 0);
        #1;
        en = rd_en;
        if (en[0]) begin
            if (rd_empty[0]) viol++;
            else p0 = q0.pop_front();
            reads[0]++;
            last_rd[0] = edge_n + 1;
        end
        if (en[1]) begin
            if (rd_empty[1]) viol++;
            else p1 = q1.pop_front();
            reads[1]++;
            last_rd[1] = edge_n + 1;
        end
        @(posedge clk);
        #1;
        edge_n++;
        start = '0;
        if (en[0]) rd_data[0] = p0;
        if (pipe1_v) rd_data[1] = pipe1_val;
        pipe1_v   = en[1];
        pipe1_val = p1;
        for (int i = 0; i < 2; i++) if (done[i] && done_edge[i] == 0) done_edge[i] = edge_n;
        @(negedge clk);
    endtask

    task automatic run_burst(input int unsigned inst, input int unsigned prefill,
                             input int unsigned gap, input int unsigned push_pct,
                             input bit poke, input string tag);
        int unsigned exp_err;
        int unsigned exp_first;
        int unsigned n_push;
        int unsigned budget;
        logic [1:0]  smask;
        logic [8:0]  wc_b;
        logic [7:0]  ec_b;
        bit          poked;
        exp_err   = 0;
        exp_first = 511;
        for (int i = 0; i < 256; i++) begin
            if (wbuf[i] !== 16'(32'hFFFF - i)) begin
                if (exp_first == 511) exp_first = i;
                if (exp_err < 255) exp_err++;
            end
        end
        smask  = (inst == 0) ? 2'b01 : 2'b10;
        n_push = 0;
        while (n_push < prefill) begin
            push(inst, wbuf[n_push]);
            n_push++;
        end
        reads[inst]     = 0;
        last_rd[inst]   = 0;
        done_edge[inst] = 0;
        viol            = 0;
        poked           = 1'b0;
        cyc(smask);
        chk({tag, "_start_busy"}, 32'(busy[inst]), 1);
        chk({tag, "_start_done_low"}, 32'(done[inst]), 0);
        for (int unsigned i = 0; i < gap; i++) cyc(2'b00);
        budget = 0;
        while (!done[inst] && budget < 3000) begin
            if (n_push < 256 && $urandom_range(99) < push_pct) begin
                push(inst, wbuf[n_push]);
                n_push++;
            end
            if (poke && !poked && reads[inst] >= 60) begin
                poked = 1'b1;
                wc_b  = wc[inst];
                ec_b  = ec[inst];
                cyc(smask);
                chk({tag, "_poke_busy"}, 32'(busy[inst]), 1);
                chk({tag, "_poke_wc_kept"},
                    32'((int'(wc[inst]) - int'(wc_b)) inside {0, 1}), 1);
                chk({tag, "_poke_ec_kept"}, 32'(ec[inst]), 32'(ec_b));
            end else begin
                cyc(2'b00);
            end
            budget++;
        end
        chk({tag, "_done"}, 32'(done[inst]), 1);
        chk({tag, "_reads"}, reads[inst], 256);
        chk({tag, "_word_cnt"}, 32'(wc[inst]), 256);
        chk({tag, "_err_cnt"}, 32'(ec[inst]), exp_err);
        chk({tag, "_first_err"}, 32'(fe[inst]), exp_first);
        chk({tag, "_pass"}, 32'(pass[inst]), 32'(exp_err == 0));
        chk({tag, "_done_latency"}, done_edge[inst] - last_rd[inst], (inst == 0) ? 2 : 3);
        chk({tag, "_no_empty_read"}, viol, 0);
        repeat (3) cyc(2'b00);
        chk({tag, "_done_held"}, 32'(done[inst]), 1);
        chk({tag, "_idle_rd_en"}, 32'(rd_en[inst]), 0);
    endtask

    task automatic chk_reset(input int unsigned inst, input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en[inst]), 0);
        chk({tag, "_busy"}, 32'(busy[inst]), 0);
        chk({tag, "_done"}, 32'(done[inst]), 0);
        chk({tag, "_pass"}, 32'(pass[inst]), 0);
        chk({tag, "_word_cnt"}, 32'(wc[inst]), 0);
        chk({tag, "_err_cnt"}, 32'(ec[inst]), 0);
        chk({tag, "_first_err"}, 32'(fe[inst]), 32'h1FF);
    endtask

    initial begin
        int unsigned budget;
        tb_rst     = 1'b1;
        start      = '0;
        rd_empty   = 2'b11;
        rd_data[0] = '0;
        rd_data[1] = '0;
        reads[0] = 0; reads[1] = 0;
        last_rd[0] = 0; last_rd[1] = 0;
        done_edge[0] = 0; done_edge[1] = 0;
        repeat (3) @(negedge clk);
        chk_reset(0, "por0");
        chk_reset(1, "por1");
        tb_rst = 1'b0;
        @(negedge clk);

        fill_clean();
        run_burst(0, 256, 0, 100, 1'b0, "clean");

        fill_clean();
        run_burst(0, 100, 20, 60, 1'b0, "stall");

        fill_clean();
        wbuf[5] = 16'h1234;
        run_burst(0, 256, 0, 100, 1'b0, "idx5");

        for (int i = 0; i < 256; i++) wbuf[i] = '0;
        run_burst(0, 256, 0, 100, 1'b0, "zeros");

        for (int r = 0; r < 3; r++) begin
            fill_clean();
            for (int i = 0; i < 256; i++)
                if ($urandom_range(15) == 0) wbuf[i] = 16'($urandom);
            run_burst(0, $urandom_range(256), $urandom_range(10),
                      30 + $urandom_range(70), 1'b0, "rand");
        end

        fill_clean();
        run_burst(0, 256, 0, 100, 1'b1, "busy_start");

        // Reset mid-burst after 50 reads.
        fill_clean();
        for (int i = 0; i < 256; i++) push(0, wbuf[i]);
        reads[0] = 0;
        cyc(2'b01);
        budget = 0;
        while (reads[0] < 50 && budget < 500) begin
            cyc(2'b00);
            budget++;
        end
        chk("mid_reads50", 32'(reads[0] >= 50), 1);
        chk("mid_busy", 32'(busy[0]), 1);
        tb_rst = 1'b1;
        #1;
        chk_reset(0, "mid_rst");
        q0.delete();
        q1.delete();
        pipe1_v = 1'b0;
        repeat (2) @(negedge clk);
        tb_rst = 1'b0;
        @(negedge clk);
        fill_clean();
        run_burst(0, 256, 0, 100, 1'b0, "after_rst");

        fill_clean();
        run_burst(1, 256, 0, 100, 1'b0, "oreg_clean");

        fill_clean();
        for (int i = 0; i < 256; i++)
            if ($urandom_range(7) == 0) wbuf[i] = 16'($urandom);
        run_burst(1, $urandom_range(256), 5, 50, 1'b0, "oreg_rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
